// File: rtl/int4_fp16_operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : int4_fp16_pkg
// Description : Shared types and constants for the INT4 x FP16 operand feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package int4_fp16_pkg;

    typedef logic [15:0]        fp16_t;
    typedef logic signed [3:0]  int4_t;

    // Nibbles per weight word for the default 32-bit word width
    localparam int NIB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

    // True for +0 and -0 (sign bit ignored)
    function automatic logic fp16_is_zero(input fp16_t v);
        return (v[14:0] == 15'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/int4_fp16_operand_feeder_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : int4_weight_unpacker
// Description : Holds one packed weight word and hands out its nibbles LSB
//               first; fetches a new word only while the job still needs one.
// Revision    : 1.0 - initial release
// ============================================================================
module int4_weight_unpacker
    import int4_fp16_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_run,
    input  logic              i_consume,
    input  logic [LEN_W-1:0]  i_rem,
    input  logic              i_w_valid,
    output logic              o_w_ready,
    input  logic [WORD_W-1:0] i_w_data,
    output logic              o_buf_valid,
    output int4_t             o_nibble
);

    localparam int c_NIB   = WORD_W / 4;
    localparam int c_IDX_W = $clog2(c_NIB);

    logic [WORD_W-1:0]  r_word;
    logic [c_IDX_W-1:0] r_nib_idx;
    logic               r_buf_valid;

    logic w_last_nib;
    logic w_wrap;
    logic w_need_word;
    logic w_fill;

    assign w_last_nib = (r_nib_idx == c_IDX_W'(c_NIB - 1));
    assign w_wrap     = i_consume && w_last_nib;

    // A word is fetched only if pairs remain beyond what the buffer still holds
    assign w_need_word = r_buf_valid ? (w_wrap && (i_rem > LEN_W'(1)))
                                     : (i_rem != '0);
    assign o_w_ready   = i_run && w_need_word;
    assign w_fill      = i_w_valid && o_w_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_nib_idx   <= '0;
            r_buf_valid <= 1'b0;
        end else if (!i_run) begin
            // Leftover nibbles of the job's final word are dropped here
            r_nib_idx   <= '0;
            r_buf_valid <= 1'b0;
        end else begin
            if (i_consume) begin
                r_nib_idx <= w_last_nib ? '0 : r_nib_idx + 1'b1;
            end
            if (w_fill) begin
                r_word      <= i_w_data;
                r_buf_valid <= 1'b1;
            end else if (w_wrap) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign o_buf_valid = r_buf_valid;
    assign o_nibble    = int4_t'(r_word[{r_nib_idx, 2'b00} +: 4]);

endmodule
`default_nettype wire

// File: rtl/int4_fp16_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : int4_fp16_operand_feeder
// Description : Pairs FP16 activations with unpacked INT4 weights, one pair
//               per cycle, for the int4_fp16_mul input handshake.
//               Optional build macro FEEDER_ZERO_SKIP_EN suppresses pairs with
//               a zero weight or zero activation (job's final pair excepted).
// Revision    : 1.0 - initial release
// ============================================================================
module int4_fp16_operand_feeder
    import int4_fp16_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [WORD_W-1:0] w_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [15:0]       a_fp16,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_fp16,
    output logic [3:0]        out_int4,
    output logic              out_last,
    output logic              done
);

    feeder_state_e r_state;
    feeder_state_e w_state_nxt;

    logic [LEN_W-1:0] r_rem;
    logic             r_out_valid;
    fp16_t            r_out_fp16;
    logic [3:0]       r_out_int4;
    logic             r_out_last;
    logic             r_done;

    logic  w_cmd_hs;
    logic  w_out_hs;
    logic  w_room;
    logic  w_run;
    logic  w_buf_valid;
    int4_t w_nibble;
    logic  w_load_ok;
    logic  w_fire;
    logic  w_rem_one;
    logic  w_emit;

    assign cmd_ready = (r_state == IDLE);
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_out_hs  = r_out_valid && out_ready;
    assign w_room    = !r_out_valid || out_ready;
    assign w_run     = (r_state == RUN);
    assign w_rem_one = (r_rem == LEN_W'(1));

    assign w_load_ok = w_run && (r_rem != '0) && w_buf_valid && w_room;
    assign a_ready   = w_load_ok;
    assign w_fire    = w_load_ok && a_valid;

`ifdef FEEDER_ZERO_SKIP_EN
    assign w_emit = w_rem_one || !((w_nibble == 4'sd0) || fp16_is_zero(a_fp16));
`else
    assign w_emit = 1'b1;
`endif

    int4_weight_unpacker #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) u_unpacker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_run       (w_run),
        .i_consume   (w_fire),
        .i_rem       (r_rem),
        .i_w_valid   (w_valid),
        .o_w_ready   (w_ready),
        .i_w_data    (w_data),
        .o_buf_valid (w_buf_valid),
        .o_nibble    (w_nibble)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cmd_hs && (cmd_len != '0)) w_state_nxt = RUN;
            RUN:     if (w_fire && w_rem_one)         w_state_nxt = DRAIN;
            DRAIN:   if (w_out_hs && r_out_last)      w_state_nxt = IDLE;
            default:                                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_fp16  <= '0;
            r_out_int4  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_rem <= cmd_len;
            end else if (w_fire) begin
                r_rem <= r_rem - LEN_W'(1);
            end

            // A suppressed pair still retires any pair handed off this cycle
            if (w_fire) begin
                r_out_valid <= w_emit;
                if (w_emit) begin
                    r_out_fp16 <= a_fp16;
                    r_out_int4 <= w_nibble;
                    r_out_last <= w_rem_one;
                end
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end

            r_done <= ((r_state == DRAIN) && w_out_hs && r_out_last)
                   || (w_cmd_hs && (cmd_len == '0));
        end
    end

    assign out_valid = r_out_valid;
    assign out_fp16  = r_out_fp16;
    assign out_int4  = r_out_int4;
    assign out_last  = r_out_last;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_int4_fp16_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_int4_fp16_operand_feeder
// Description : Directed and randomized bench with a pair-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int4_fp16_operand_feeder;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 16;
    localparam int NIB    = WORD_W / 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              w_valid;
    logic              w_ready;
    logic [WORD_W-1:0] w_data;
    logic              a_valid;
    logic              a_ready;
    logic [15:0]       a_fp16;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_fp16;
    logic [3:0]        out_int4;
    logic              out_last;
    logic              done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] f;
        logic [3:0]  n;
        logic        l;
        int          idx;
    } pair_t;

    logic [WORD_W-1:0] tw[$];
    logic [15:0]       ta[$];
    pair_t             exp_q[$];

    int4_fp16_operand_feeder #(
        .WORD_W (WORD_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_fp16    (a_fp16),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp16  (out_fp16),
        .out_int4  (out_int4),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected output stream: pair i = (act i, nibble i%NIB of word i/NIB)
    task automatic build_model(input int len);
        logic [WORD_W-1:0] wd;
        logic [3:0]        nb;
        bit                keep;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            wd   = tw[i / NIB];
            nb   = 4'((wd >> (4 * (i % NIB))) & 'hF);
            keep = 1'b1;
`ifdef FEEDER_ZERO_SKIP_EN
            keep = (nb != 4'd0 && ta[i][14:0] != 15'd0) || (i == len - 1);
`endif
            if (keep) exp_q.push_back('{ta[i], nb, (i == len - 1), i});
        end
    endtask

    task automatic run_job(input int len, input int wp, input int ap, input int rp,
                           input bit pat, input int abort_after);
        pair_t       e;
        int          wi, ai, nw, npairs, dones, last_k;
        bit          stalled, saw_last, finished, full;
        logic [15:0] hf;
        logic [3:0]  hn;
        logic        hl;
        wi = 0; ai = 0; npairs = 0; dones = 0; last_k = -10;
        stalled = 0; saw_last = 0; finished = 0;
        hf = '0; hn = '0; hl = 1'b0;
        full = (wp == 100) && (ap == 100) && (rp == 100) && !pat;
        nw = (len + NIB - 1) / NIB;
        build_model(len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        #1 chk("cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 2000 && !finished; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            w_valid   = ($urandom_range(99) < wp);
            w_data    = (wi < nw) ? tw[wi] : WORD_W'($urandom);
            a_valid   = ($urandom_range(99) < ap);
            a_fp16    = (ai < len) ? ta[ai] : 16'($urandom);
            out_ready = pat ? (k % 3 == 0) : ($urandom_range(99) < rp);
            #1;
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_fp16", out_fp16, hf);
                chk("hold_int4", out_int4, hn);
                chk("hold_last", out_last, hl);
            end
            if (out_valid && !out_ready) chk("a_ready_stall", a_ready, 0);
            if (w_valid && w_ready) wi++;
            if (a_valid && a_ready) ai++;
            if (done) dones++;
            if (saw_last && k == last_k + 1) chk("done_pulse", done, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pair", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_fp16", out_fp16, e.f);
                    chk("pair_int4", out_int4, e.n);
                    chk("pair_last", out_last, e.l);
                    if (full) chk("pair_cycle", k, 2 + e.idx);
                end
                if (out_last) begin
                    saw_last = 1;
                    last_k   = k;
                end
                npairs++;
                if (abort_after > 0 && npairs == abort_after) finished = 1;
            end
            stalled = out_valid && !out_ready;
            hf = out_fp16; hn = out_int4; hl = out_last;
            if (saw_last && k == last_k + 2) finished = 1;
        end
        if (abort_after > 0) begin
            chk("abort_reached", finished, 1);
            exp_q.delete();
        end else begin
            chk("job_finished", finished, 1);
            chk("pairs_left", exp_q.size(), 0);
            chk("w_handshakes", wi, nw);
            chk("a_handshakes", ai, len);
            chk("done_count", dones, 1);
            w_valid = 1'b0; a_valid = 1'b0; out_ready = 1'b0;
        end
    endtask

    task automatic load_test1();
        tw = '{32'h7680_5F31};
        ta = '{16'h3C00, 16'h4000, 16'h3E00, 16'h0000,
               16'h3C00, 16'h3800, 16'hC000, 16'h3C00};
    endtask

    initial begin
        int len;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_fp16 = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_fp16", out_fp16, 0);
        chk("rst_out_int4", out_int4, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_a_ready", a_ready, 0);
        rst_n = 1'b1;

        // Reference job at full throughput, then with out_ready 1,0,0 pattern
        load_test1();
        run_job(8, 100, 100, 100, 0, 0);
        run_job(8, 100, 100, 0, 1, 0);

        // Two words, only two nibbles of the second used
        tw = '{32'h7680_5F31, 32'h0000_0021};
        ta.delete();
        for (int i = 0; i < 10; i++) ta.push_back(16'h3C00 + 16'(i));
        run_job(10, 100, 100, 100, 0, 0);

        // Zero-length jobs, second accepted in the done cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = '0; w_valid = 1'b1; a_valid = 1'b1; out_ready = 1'b1;
        #1 chk("z_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        #1;
        chk("z_done", done, 1);
        chk("z_out_valid", out_valid, 0);
        chk("z_w_ready", w_ready, 0);
        chk("z_a_ready", a_ready, 0);
        chk("z_cmd_ready_done", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 chk("z_done_b2b", done, 1);
        @(negedge clk);
        #1 chk("z_done_clear", done, 0);
        w_valid = 1'b0; a_valid = 1'b0; out_ready = 1'b0;

        // Reset mid-job after three pairs, then a clean rerun
        load_test1();
        run_job(8, 100, 100, 100, 0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; w_valid = 1'b0; a_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("ab_out_valid", out_valid, 0);
        chk("ab_out_fp16", out_fp16, 0);
        chk("ab_out_int4", out_int4, 0);
        chk("ab_out_last", out_last, 0);
        chk("ab_done", done, 0);
        chk("ab_cmd_ready", cmd_ready, 1);
        run_job(8, 100, 100, 100, 0, 0);

        // Job whose final weight nibble is zero
        tw = '{32'h0000_0321};
        ta = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
        run_job(5, 100, 100, 100, 0, 0);

        // Randomized jobs with random valid/ready gaps
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 24));
            tw.delete(); ta.delete();
            for (int i = 0; i < (len + NIB - 1) / NIB; i++) tw.push_back(WORD_W'($urandom));
            for (int i = 0; i < len; i++)
                ta.push_back(($urandom_range(3) == 0) ? 16'h8000 : 16'($urandom));
            run_job(len, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                    int'($urandom_range(30, 100)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
